// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, data-size constants and size decode
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam logic [3:0] DSIZE_5 = 4'd5;
  localparam logic [3:0] DSIZE_7 = 4'd7;
  localparam logic [3:0] DSIZE_8 = 4'd8;

  // Unsupported sizes fall back to a full 8-bit character
  function automatic logic [3:0] decode_dsize(input logic [3:0] size);
    case (size)
      DSIZE_5: return DSIZE_5;
      DSIZE_7: return DSIZE_7;
      default: return DSIZE_8;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_block_if.sv
// rtl/uart_tx_block_if.sv - character handshake and serial line bundle
interface uart_tx_block_if;

  logic [7:0]  tx_data;
  logic        tx_start;
  logic [3:0]  data_size;
  logic [13:0] bit_period;
  logic        serial_out;
  logic        tx_busy;
  logic        tx_done;

  modport master (
    output tx_data, tx_start, data_size, bit_period,
    input  serial_out, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_start, data_size, bit_period,
    output serial_out, tx_busy, tx_done
  );

endinterface

// File: rtl/uart_tx_timer.sv
// rtl/uart_tx_timer.sv - bit-period counter producing one tick per serial bit
module uart_tx_timer (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [13:0] bp,
  output logic        bit_tick
);

  logic [13:0] cnt;

  // Tick on the last cycle of a bit so the FSM moves on at the bit boundary
  assign bit_tick = enable && (cnt == bp);

  // Count 1..bp; clear preloads 1 so the first frame cycle is count 1
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= 14'd1;
    end else if (enable) begin
      cnt <= bit_tick ? 14'd1 : cnt + 14'd1;
    end
  end

endmodule

// File: rtl/uart_tx_block.sv
// rtl/uart_tx_block.sv - UART transmitter: start bit, LSB-first data, one stop bit
module uart_tx_block
  import uart_pkg::*;
#(
  parameter int MIN_BIT_PERIOD = 2
) (
  input  logic            clk,
  input  logic            n_rst,
  uart_tx_block_if.slave  bus
);

  localparam logic [13:0] MIN_BP = 14'(MIN_BIT_PERIOD);

  tx_state_t   state;
  logic [7:0]  data_q;
  logic [3:0]  nbits_q;
  logic [13:0] bp_q;
  logic [2:0]  bit_idx;
  logic        serial_q;
  logic        done_q;
  logic        accept;
  logic        bit_tick;

  assign accept = (state == IDLE) && bus.tx_start;

  uart_tx_timer u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (accept),
    .enable   (state != IDLE),
    .bp       (bp_q),
    .bit_tick (bit_tick)
  );

  // Frame FSM; all frame parameters are captured at accept so later input changes are ignored
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      data_q   <= '0;
      nbits_q  <= '0;
      bp_q     <= '0;
      bit_idx  <= '0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            data_q   <= bus.tx_data;
            nbits_q  <= decode_dsize(bus.data_size);
            bp_q     <= (bus.bit_period < MIN_BP) ? MIN_BP : bus.bit_period;
            bit_idx  <= '0;
            serial_q <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (bit_tick) begin
            serial_q <= data_q[0];
            state    <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if ({1'b0, bit_idx} == nbits_q - 4'd1) begin
              serial_q <= 1'b1;
              state    <= STOP;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              serial_q <= data_q[bit_idx + 3'd1];
            end
          end
        end
        STOP: begin
          if (bit_tick) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.serial_out = serial_q;
  assign bus.tx_busy    = (state != IDLE);
  assign bus.tx_done    = done_q;

endmodule
